wb_rr_arbiter: RTL and testbench

Round-robin Wishbone B4 (classic, single-outstanding) arbiter that shares one slave port, typically the RAM behind the memory bus, between N masters: instruction fetch, data port and a future DMA/debug master. It replaces fixed-priority sharing, so no master can starve another. Bus ownership is locked for the full `cyc` tenure. A programmable watchdog terminates stalled transfers with `err`.

---
 rtl/wb_rr_arbiter.sv | 159 +++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone B4 classic slave between N masters.
// Ownership is held for the whole cyc tenure. A watchdog ends stalled strobes
// with a one-cycle error phase.
module wb_rr_arbiter #(
  parameter int N       = 3,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      m_cyc,
  input  logic [N-1:0]      m_stb,
  input  logic [N-1:0]      m_we,
  input  logic [N*AW-1:0]   m_adr,
  input  logic [N*DW-1:0]   m_dat_w,
  input  logic [N*DW/8-1:0] m_sel,
  output logic [DW-1:0]     m_dat_r,
  output logic [N-1:0]      m_ack,
  output logic [N-1:0]      m_err,
  output logic              s_cyc,
  output logic              s_stb,
  output logic              s_we,
  output logic [AW-1:0]     s_adr,
  output logic [DW-1:0]     s_dat_w,
  output logic [DW/8-1:0]   s_sel,
  input  logic [DW-1:0]     s_dat_r,
  input  logic              s_ack,
  input  logic              s_err,
  output logic [N-1:0]      grant,
  output logic              timeout_evt
);

  localparam int SW = DW / 8;
  localparam int LW = $clog2(N);
  // Keep the counter at least one bit wide even when the watchdog is disabled.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ERR} state_t;

  state_t         r_state, w_state_next;
  logic [N-1:0]   r_grant, w_grant_next;
  logic [LW-1:0]  r_last, w_last_next;
  logic [CW-1:0]  r_cnt, w_cnt_next;

  logic           w_found;
  logic [LW-1:0]  w_win;
  logic           w_g_cyc;
  logic           w_g_stb;
  logic           w_busy;
  logic           w_stall;

  assign w_busy  = (r_state == ST_BUSY);
  assign w_g_cyc = |(m_cyc & r_grant);
  assign w_g_stb = |(m_stb & r_grant);
  assign w_stall = s_stb & ~s_ack & ~s_err;

  assign s_cyc       = w_busy & w_g_cyc;
  assign s_stb       = w_busy & w_g_stb;
  assign m_dat_r     = s_dat_r;
  assign grant       = r_grant;
  assign timeout_evt = (r_state == ST_ERR);

  // Responses are steered only to the owner; the error phase forces err and drops any late ack.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_resp
      assign m_ack[gi] = r_grant[gi] & w_busy & s_ack;
      assign m_err[gi] = r_grant[gi] & ((w_busy & s_err) | (r_state == ST_ERR));
    end
  endgenerate

  // AND-OR mux of the owner's request fields; all zero when nobody holds the grant.
  always_comb begin
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    for (int i = 0; i < N; i++) begin
      s_we    = s_we    | (r_grant[i] & m_we[i]);
      s_adr   = s_adr   | ({AW{r_grant[i]}} & m_adr[i*AW +: AW]);
      s_dat_w = s_dat_w | ({DW{r_grant[i]}} & m_dat_w[i*DW +: DW]);
      s_sel   = s_sel   | ({SW{r_grant[i]}} & m_sel[i*SW +: SW]);
    end
  end

  // Rotating search for the first requester after the most recent owner.
  // The owner's own index is visited last, so it only wins when alone.
  always_comb begin
    int v_idx;
    w_found = 1'b0;
    w_win   = '0;
    v_idx   = 0;
    for (int k = 1; k <= N; k++) begin
      v_idx = (int'(r_last) + k) % N;
      if (!w_found && m_cyc[v_idx]) begin
        w_found = 1'b1;
        w_win   = LW'(v_idx);
      end
    end
  end

  // Next-state, grant handover and watchdog counting.
  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_last_next  = r_last;
    w_cnt_next   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant_next = {{(N-1){1'b0}}, 1'b1} << w_win;
          w_last_next  = w_win;
          w_state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!w_g_cyc) begin
          // Owner released: hand over at this edge, or fall back to idle.
          if (w_found) begin
            w_grant_next = {{(N-1){1'b0}}, 1'b1} << w_win;
            w_last_next  = w_win;
          end else begin
            w_grant_next = '0;
            w_state_next = ST_IDLE;
          end
        end else if ((TIMEOUT > 0) && w_stall) begin
          w_cnt_next = r_cnt + 1'b1;
          if (int'(r_cnt) + 1 >= TIMEOUT) begin
            w_state_next = ST_ERR;
          end
        end
      end
      ST_ERR: begin
        // Single error cycle; the grant is kept so the master can release.
        w_state_next = ST_BUSY;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_grant_next = '0;
      end
    endcase
  end

  // State registers; last resets to N-1 so master 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_last  <= LW'(N - 1);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_grant <= w_grant_next;
      r_last  <= w_last_next;
      r_cnt   <= w_cnt_next;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed scenarios plus random traffic, all checked
// every cycle against an owner/last/stall-count reference model.
module tb_wb_rr_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      m_cyc, m_stb, m_we;
  logic [N*AW-1:0]   m_adr;
  logic [N*DW-1:0]   m_dat_w;
  logic [N*SW-1:0]   m_sel;
  logic [DW-1:0]     m_dat_r;
  logic [N-1:0]      m_ack, m_err;
  logic              s_cyc, s_stb, s_we;
  logic [AW-1:0]     s_adr;
  logic [DW-1:0]     s_dat_w;
  logic [SW-1:0]     s_sel;
  logic [DW-1:0]     s_dat_r;
  logic              s_ack, s_err;
  logic [N-1:0]      grant;
  logic              timeout_evt;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.N(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
    .m_dat_w(m_dat_w), .m_sel(m_sel), .m_dat_r(m_dat_r),
    .m_ack(m_ack), .m_err(m_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_w(s_dat_w), .s_sel(s_sel), .s_dat_r(s_dat_r),
    .s_ack(s_ack), .s_err(s_err),
    .grant(grant), .timeout_evt(timeout_evt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: owner index (-1 = idle), last owner, stall count, error phase.
  int own, last, wd;
  bit in_err;
  bit mvalid = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic int pick(input int from, input logic [N-1:0] req);
    for (int k = 1; k <= N; k++) begin
      int i = (from + k) % N;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_check();
    bit busy;
    logic [N-1:0] eg, ea, ee;
    busy = (own >= 0) && !in_err;
    eg = (own >= 0) ? (N'(1) << own) : '0;
    ea = busy ? (N'(s_ack) << own) : '0;
    ee = (own >= 0) ? (in_err ? (N'(1) << own) : (busy ? (N'(s_err) << own) : '0)) : '0;
    chk("grant", 64'(grant), 64'(eg));
    chk("s_cyc", 64'(s_cyc), busy ? 64'(m_cyc[own]) : 64'd0);
    chk("s_stb", 64'(s_stb), busy ? 64'(m_stb[own]) : 64'd0);
    chk("m_ack", 64'(m_ack), 64'(ea));
    chk("m_err", 64'(m_err), 64'(ee));
    chk("timeout_evt", 64'(timeout_evt), 64'(in_err));
    chk("s_adr", 64'(s_adr), (own >= 0) ? 64'(m_adr[own*AW +: AW]) : 64'd0);
    chk("s_dat_w", 64'(s_dat_w), (own >= 0) ? 64'(m_dat_w[own*DW +: DW]) : 64'd0);
    chk("s_sel", 64'(s_sel), (own >= 0) ? 64'(m_sel[own*SW +: SW]) : 64'd0);
    if (busy) chk("s_we", 64'(s_we), 64'(m_we[own]));
    chk("m_dat_r", 64'(m_dat_r), 64'(s_dat_r));
  endtask

  task automatic model_step();
    int w;
    if (rst) begin
      own = -1; last = N - 1; wd = 0; in_err = 1'b0; mvalid = 1'b1;
    end else if (!mvalid) begin
      own = -1;
    end else if (own < 0) begin
      w = pick(last, m_cyc);
      if (w >= 0) begin own = w; last = w; end
      wd = 0;
    end else if (in_err) begin
      in_err = 1'b0; wd = 0;
    end else if (!m_cyc[own]) begin
      w = pick(own, m_cyc);
      own = w;
      if (w >= 0) last = w;
      wd = 0;
    end else if (m_stb[own] && !s_ack && !s_err) begin
      wd++;
      if (wd >= TO) in_err = 1'b1;
    end else begin
      wd = 0;
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    @(negedge clk);
    if (mvalid) model_check();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0;
    m_adr = '0; m_dat_w = '0; m_sel = '0;
    s_dat_r = '0; s_ack = 1'b0; s_err = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] gq [$];
    logic [N-1:0] acked;
    logic [N-1:0] exp_order [4];
    logic [DW-1:0] rd_val;
    int ackn [N];
    int wcnt, t_stb, t_err;
    bit was_stb, ack_seen;

    rst = 1'b1;
    clear_inputs();
    tick();
    do_reset();
    chk("reset_grant", 64'(grant), 64'd0);
    chk("reset_s_cyc", 64'(s_cyc), 64'd0);

    // Round robin: all three request together; slave acks in the second strobe cycle.
    exp_order[0] = 3'b001; exp_order[1] = 3'b010;
    exp_order[2] = 3'b100; exp_order[3] = 3'b001;
    for (int i = 0; i < N; i++) ackn[i] = 0;
    m_cyc = 3'b111; m_stb = 3'b111;
    for (int i = 0; i < N; i++) m_adr[i*AW +: AW] = 32'h100 * (i + 1);
    wcnt = 0;
    for (int c = 0; c < 60 && gq.size() < 4; c++) begin
      #1;
      s_ack = s_stb && (wcnt == 1);
      s_dat_r = $urandom;
      #1;
      if (grant != 0 && (gq.size() == 0 || gq[$] != grant)) gq.push_back(grant);
      acked = m_ack;
      for (int i = 0; i < N; i++) if (acked[i]) ackn[i]++;
      was_stb = s_stb;
      tick();
      wcnt = s_ack ? 0 : (was_stb ? wcnt + 1 : 0);
      for (int i = 0; i < N; i++) begin
        m_cyc[i] = ~acked[i];
        m_stb[i] = ~acked[i];
      end
    end
    chk("rr_count", 64'(gq.size()), 64'd4);
    for (int k = 0; k < 4 && k < gq.size(); k++) chk($sformatf("rr_order%0d", k), 64'(gq[k]), 64'(exp_order[k]));
    for (int i = 0; i < N; i++) chk($sformatf("rr_acks%0d", i), 64'(ackn[i]), 64'd1);

    // Watchdog: master 0 strobes, slave never answers.
    do_reset();
    m_cyc = 3'b001; m_stb = 3'b001;
    t_stb = -1; t_err = -1; ack_seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (s_stb && t_stb < 0) t_stb = c;
      if (m_err[0] && t_err < 0) begin
        t_err = c;
        chk("to_s_cyc", 64'(s_cyc), 64'd0);
        chk("to_evt", 64'(timeout_evt), 64'd1);
      end
      if (m_ack != 0) ack_seen = 1'b1;
      tick();
    end
    chk("to_stb_cycle", 64'(t_stb), 64'd1);
    chk("to_err_cycle", 64'(t_err), 64'(TO + 1));
    chk("to_no_ack", 64'(ack_seen), 64'd0);

    // Reset in the middle of a master 1 read with the ack still pending.
    do_reset();
    m_cyc = 3'b010; m_stb = 3'b010;
    tick();
    tick();
    chk("mid_grant_pre", 64'(grant), 64'b010);
    rst = 1'b1;
    tick();
    chk("mid_rst_grant", 64'(grant), 64'd0);
    chk("mid_rst_s_cyc", 64'(s_cyc), 64'd0);
    chk("mid_rst_m_ack", 64'(m_ack), 64'd0);
    rst = 1'b0;
    m_cyc = 3'b110; m_stb = 3'b110;
    tick();
    chk("post_rst_grant", 64'(grant), 64'b010);

    // Read data reaches master 2 in the same cycle as its ack.
    do_reset();
    m_cyc = 3'b100; m_stb = 3'b100;
    tick();
    rd_val = 32'hDEADBEEF;
    s_ack = 1'b1; s_dat_r = rd_val;
    #1;
    chk("rd_data", 64'(m_dat_r), 64'(rd_val));
    chk("rd_ack", 64'(m_ack), 64'b100);
    tick();

    // Random traffic, every cycle compared against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) m_cyc[i] = ~m_cyc[i];
        m_stb[i] = m_cyc[i] & ($urandom_range(0, 3) != 0);
        m_we[i]  = 1'($urandom);
        m_adr[i*AW +: AW]   = $urandom;
        m_dat_w[i*DW +: DW] = $urandom;
        m_sel[i*SW +: SW]   = SW'($urandom);
      end
      s_ack   = ($urandom_range(0, 4) == 0);
      s_err   = ($urandom_range(0, 39) == 0);
      s_dat_r = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case something above fails to make progress.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timeout");
  end

endmodule
